// File: rtl/cpu_pkg.sv
// Shared CPU definitions: IR fetch codes, fetch-sequencer state encoding and the
// default set of opcodes that carry a second (memory-address) byte.
package cpu_pkg;

    localparam logic [1:0] FETCH_HOLD = 2'b00;
    localparam logic [1:0] FETCH_P1   = 2'b01;
    localparam logic [1:0] FETCH_P2   = 2'b10;

    // bit[op] set means opcode op is followed by a memory-address byte
    localparam logic [15:0] TWO_BYTE_MASK_DEFAULT = 16'hFF00;

    typedef enum logic [2:0] {
        StF1,
        StF2,
        StDisp,
        StExec,
        StHalt
    } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch sequencer bus: memory read channel, IR capture code and execution-unit handshake.
interface fetch_ctrl_if #(
    parameter int unsigned AW = 8
);
    logic [7:0]    data;
    logic          mem_rdy;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [1:0]    fetch;
    logic          ins_valid;
    logic          exec_done;
    logic          jmp_en;
    logic [AW-1:0] jmp_addr;
    logic          halt;
    logic [AW-1:0] pc;
    logic          halted;

    modport master (
        input  data, mem_rdy, exec_done, jmp_en, jmp_addr, halt,
        output mem_rd, mem_addr, fetch, ins_valid, pc, halted
    );

    modport slave (
        output data, mem_rdy, exec_done, jmp_en, jmp_addr, halt,
        input  mem_rd, mem_addr, fetch, ins_valid, pc, halted
    );

endinterface

// File: rtl/pc_reg.sv
// Program counter: synchronous reset, increment modulo 2^AW, load with priority over increment.
module pc_reg #(
    parameter int unsigned   AW       = 8,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_inc,
    input  logic          i_load,
    input  logic [AW-1:0] i_load_addr,
    output logic [AW-1:0] o_pc
);

    logic [AW-1:0] r_pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= i_load_addr;
        end else if (i_inc) begin
            r_pc <= r_pc + AW'(1);
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: reads one or two instruction bytes, steers the IR via the
// fetch code, hands the instruction to the execution unit and applies jump/halt/next-PC.
module fetch_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned   AW            = 8,
    parameter logic [AW-1:0] RESET_PC      = '0,
    parameter logic [15:0]   TWO_BYTE_MASK = TWO_BYTE_MASK_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_ctrl_if.master  io_bus
);

    fetch_state_e  r_state;
    fetch_state_e  w_state_d;
    logic          w_inc;
    logic          w_load;
    logic          w_mem_rd;
    logic          w_ins_valid;
    logic          w_halted;
    logic [1:0]    w_fetch;
    logic [AW-1:0] w_pc;
    logic [AW-1:0] w_pc_out;

    pc_reg #(
        .AW       (AW),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_inc       (w_inc),
        .i_load      (w_load),
        .i_load_addr (io_bus.jmp_addr),
        .o_pc        (w_pc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= StF1;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_inc       = 1'b0;
        w_load      = 1'b0;
        w_mem_rd    = 1'b0;
        w_ins_valid = 1'b0;
        w_halted    = 1'b0;
        w_fetch     = FETCH_HOLD;
        case (r_state)
            StF1: begin
                w_mem_rd = 1'b1;
                if (io_bus.mem_rdy) begin
                    w_fetch   = FETCH_P1;
                    w_inc     = 1'b1;
                    w_state_d = TWO_BYTE_MASK[io_bus.data[7:4]] ? StF2 : StDisp;
                end
            end
            StF2: begin
                w_mem_rd = 1'b1;
                if (io_bus.mem_rdy) begin
                    w_fetch   = FETCH_P2;
                    w_inc     = 1'b1;
                    w_state_d = StDisp;
                end
            end
            StDisp: begin
                w_ins_valid = 1'b1;
                w_state_d   = StExec;
            end
            StExec: begin
                // jump target is loaded even when halting
                if (io_bus.exec_done) begin
                    w_load    = io_bus.jmp_en;
                    w_state_d = io_bus.halt ? StHalt : StF1;
                end
            end
            StHalt: begin
                w_halted = 1'b1;
            end
            default: begin
                w_state_d = StF1;
            end
        endcase
    end

    // Outputs are forced idle during reset so an in-flight fetch code never reaches the IR.
    assign w_pc_out         = rst_n ? w_pc : RESET_PC;
    assign io_bus.pc        = w_pc_out;
    assign io_bus.mem_addr  = w_pc_out;
    assign io_bus.mem_rd    = rst_n & w_mem_rd;
    assign io_bus.fetch     = rst_n ? w_fetch : FETCH_HOLD;
    assign io_bus.ins_valid = rst_n & w_ins_valid;
    assign io_bus.halted    = rst_n & w_halted;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl with a byte memory and a simple IR model.
module tb_fetch_ctrl;
    import cpu_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [7:0] mem [256];
    int         checks = 0;
    int         errors = 0;

    logic [1:0] s_fetch;
    logic [7:0] s_data;
    logic [7:0] ir_op;
    logic [7:0] ir_mem;
    int         p1_cnt = 0;
    int         p2_cnt = 0;

    fetch_ctrl_if #(.AW(8)) bus ();

    fetch_ctrl #(
        .AW            (8),
        .RESET_PC      (8'h00),
        .TWO_BYTE_MASK (16'hFF00)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    assign bus.data = mem[bus.mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // IR model: sample the fetch code just before the rising edge, latch on the edge
    always @(negedge clk) begin
        #4;
        s_fetch = bus.fetch;
        s_data  = bus.data;
    end

    always @(posedge clk) begin
        if (s_fetch == FETCH_P1) begin
            ir_op  <= s_data;
            p1_cnt <= p1_cnt + 1;
        end else if (s_fetch == FETCH_P2) begin
            ir_mem <= s_data;
            p2_cnt <= p2_cnt + 1;
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n         = 1'b0;
        bus.mem_rdy   = 1'b0;
        bus.exec_done = 1'b0;
        bus.jmp_en    = 1'b0;
        bus.halt      = 1'b0;
        bus.jmp_addr  = 8'h00;
        cyc();
        cyc();
    endtask

    task automatic test_reset();
        apply_reset();
        bus.mem_rdy = 1'b1;
        #1;
        checks++; if (bus.mem_rd !== 1'b0) begin errors++; $display("FAIL rst_mem_rd: got %b want 0", bus.mem_rd); end
        checks++; if (bus.fetch !== FETCH_HOLD) begin errors++; $display("FAIL rst_fetch: got %b want 00", bus.fetch); end
        checks++; if (bus.ins_valid !== 1'b0) begin errors++; $display("FAIL rst_ins_valid: got %b want 0", bus.ins_valid); end
        checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got %b want 0", bus.halted); end
        checks++; if (bus.pc !== 8'h00) begin errors++; $display("FAIL rst_pc: got %h want 00", bus.pc); end
        checks++; if (bus.mem_addr !== 8'h00) begin errors++; $display("FAIL rst_mem_addr: got %h want 00", bus.mem_addr); end
    endtask

    task automatic test_one_byte();
        int p1_start;
        int p2_start;
        mem[8'h00] = 8'h12;
        mem[8'h01] = 8'h00;
        apply_reset();
        p1_start = p1_cnt;
        p2_start = p2_cnt;
        bus.mem_rdy = 1'b1;
        rst_n = 1'b1;
        #1;
        checks++; if (bus.fetch !== FETCH_P1) begin errors++; $display("FAIL one_fetch_p1: got %b want 01", bus.fetch); end
        checks++; if (bus.mem_rd !== 1'b1) begin errors++; $display("FAIL one_mem_rd: got %b want 1", bus.mem_rd); end
        cyc(); #1;
        checks++; if (bus.ins_valid !== 1'b1) begin errors++; $display("FAIL one_ins_valid: got %b want 1", bus.ins_valid); end
        checks++; if (bus.fetch !== FETCH_HOLD) begin errors++; $display("FAIL one_fetch_disp: got %b want 00", bus.fetch); end
        checks++; if (bus.pc !== 8'h01) begin errors++; $display("FAIL one_pc: got %h want 01", bus.pc); end
        cyc();
        bus.exec_done = 1'b1;
        #1;
        checks++; if (bus.ins_valid !== 1'b0) begin errors++; $display("FAIL one_ins_pulse: got %b want 0", bus.ins_valid); end
        checks++; if (bus.mem_rd !== 1'b0) begin errors++; $display("FAIL one_exec_mem_rd: got %b want 0", bus.mem_rd); end
        cyc();
        bus.exec_done = 1'b0;
        #1;
        checks++; if (bus.mem_addr !== 8'h01) begin errors++; $display("FAIL one_next_addr: got %h want 01", bus.mem_addr); end
        checks++; if (bus.mem_rd !== 1'b1) begin errors++; $display("FAIL one_refetch: got %b want 1", bus.mem_rd); end
        checks++; if (p2_cnt !== p2_start) begin errors++; $display("FAIL one_no_p2: got %0d want %0d", p2_cnt, p2_start); end
        checks++; if (p1_cnt !== p1_start + 1) begin errors++; $display("FAIL one_p1_count: got %0d want %0d", p1_cnt, p1_start + 1); end
        checks++; if (ir_op !== 8'h12) begin errors++; $display("FAIL one_ir_op: got %h want 12", ir_op); end
    endtask

    task automatic test_two_byte();
        int p1_start;
        int p2_start;
        mem[8'h00] = 8'h9A;
        mem[8'h01] = 8'h3C;
        apply_reset();
        p1_start = p1_cnt;
        p2_start = p2_cnt;
        bus.mem_rdy = 1'b1;
        rst_n = 1'b1;
        #1;
        checks++; if (bus.fetch !== FETCH_P1) begin errors++; $display("FAIL two_fetch_p1: got %b want 01", bus.fetch); end
        cyc(); #1;
        checks++; if (bus.fetch !== FETCH_P2) begin errors++; $display("FAIL two_fetch_p2: got %b want 10", bus.fetch); end
        checks++; if (bus.mem_addr !== 8'h01) begin errors++; $display("FAIL two_addr2: got %h want 01", bus.mem_addr); end
        checks++; if (bus.ins_valid !== 1'b0) begin errors++; $display("FAIL two_early_valid: got %b want 0", bus.ins_valid); end
        cyc(); #1;
        checks++; if (bus.ins_valid !== 1'b1) begin errors++; $display("FAIL two_ins_valid: got %b want 1", bus.ins_valid); end
        checks++; if (bus.pc !== 8'h02) begin errors++; $display("FAIL two_pc: got %h want 02", bus.pc); end
        cyc();
        bus.exec_done = 1'b1;
        #1;
        checks++; if (bus.ins_valid !== 1'b0) begin errors++; $display("FAIL two_ins_pulse: got %b want 0", bus.ins_valid); end
        checks++; if (ir_op[7:4] !== 4'h9) begin errors++; $display("FAIL two_ir_ins: got %h want 9", ir_op[7:4]); end
        checks++; if (ir_op[3:0] !== 4'hA) begin errors++; $display("FAIL two_ir_addr_reg: got %h want A", ir_op[3:0]); end
        checks++; if (ir_mem !== 8'h3C) begin errors++; $display("FAIL two_ir_addr_mem: got %h want 3C", ir_mem); end
        checks++; if (p1_cnt !== p1_start + 1 || p2_cnt !== p2_start + 1) begin
            errors++; $display("FAIL two_counts: got p1=%0d p2=%0d want p1=%0d p2=%0d",
                               p1_cnt - p1_start, p2_cnt - p2_start, 1, 1);
        end
        cyc();
        bus.exec_done = 1'b0;
    endtask

    task automatic test_wait_states();
        int         p1_start;
        logic [1:0] exp_fetch;
        mem[8'h00] = 8'h12;
        apply_reset();
        p1_start = p1_cnt;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.mem_rdy = (i == 3);
            exp_fetch   = (i == 3) ? FETCH_P1 : FETCH_HOLD;
            #1;
            checks++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 8'h00) begin
                errors++; $display("FAIL wait_bus[%0d]: got rd=%b addr=%h want rd=1 addr=00", i, bus.mem_rd, bus.mem_addr);
            end
            checks++; if (bus.fetch !== exp_fetch) begin
                errors++; $display("FAIL wait_fetch[%0d]: got %b want %b", i, bus.fetch, exp_fetch);
            end
            cyc();
        end
        #1;
        checks++; if (bus.ins_valid !== 1'b1 || bus.pc !== 8'h01) begin
            errors++; $display("FAIL wait_done: got valid=%b pc=%h want valid=1 pc=01", bus.ins_valid, bus.pc);
        end
        checks++; if (p1_cnt !== p1_start + 1) begin errors++; $display("FAIL wait_p1_once: got %0d want 1", p1_cnt - p1_start); end
    endtask

    task automatic test_jump();
        mem[8'h00] = 8'h12;
        mem[8'h40] = 8'h12;
        apply_reset();
        bus.mem_rdy = 1'b1;
        rst_n = 1'b1;
        cyc();
        cyc();
        bus.jmp_en   = 1'b1;
        bus.jmp_addr = 8'h40;
        cyc(); #1;
        checks++; if (bus.pc !== 8'h01 || bus.mem_rd !== 1'b0) begin
            errors++; $display("FAIL jmp_ignored: got pc=%h rd=%b want pc=01 rd=0", bus.pc, bus.mem_rd);
        end
        bus.exec_done = 1'b1;
        cyc();
        bus.exec_done = 1'b0;
        bus.jmp_en    = 1'b0;
        #1;
        checks++; if (bus.mem_addr !== 8'h40) begin errors++; $display("FAIL jmp_addr: got %h want 40", bus.mem_addr); end
        checks++; if (bus.fetch !== FETCH_P1) begin errors++; $display("FAIL jmp_fetch: got %b want 01", bus.fetch); end
    endtask

    task automatic test_wrap();
        mem[8'h00] = 8'h12;
        mem[8'hFF] = 8'h85;
        apply_reset();
        bus.mem_rdy = 1'b1;
        rst_n = 1'b1;
        cyc();
        cyc();
        bus.exec_done = 1'b1;
        bus.jmp_en    = 1'b1;
        bus.jmp_addr  = 8'hFF;
        cyc();
        bus.exec_done = 1'b0;
        bus.jmp_en    = 1'b0;
        #1;
        checks++; if (bus.mem_addr !== 8'hFF || bus.fetch !== FETCH_P1) begin
            errors++; $display("FAIL wrap_first: got addr=%h fetch=%b want addr=FF fetch=01", bus.mem_addr, bus.fetch);
        end
        cyc(); #1;
        checks++; if (bus.mem_addr !== 8'h00 || bus.fetch !== FETCH_P2) begin
            errors++; $display("FAIL wrap_second: got addr=%h fetch=%b want addr=00 fetch=10", bus.mem_addr, bus.fetch);
        end
        cyc(); #1;
        checks++; if (bus.pc !== 8'h01 || bus.ins_valid !== 1'b1) begin
            errors++; $display("FAIL wrap_final: got pc=%h valid=%b want pc=01 valid=1", bus.pc, bus.ins_valid);
        end
        checks++; if (ir_op !== 8'h85 || ir_mem !== 8'h12) begin
            errors++; $display("FAIL wrap_ir: got op=%h mem=%h want op=85 mem=12", ir_op, ir_mem);
        end
    endtask

    task automatic test_halt();
        mem[8'h00] = 8'h12;
        apply_reset();
        bus.mem_rdy = 1'b1;
        rst_n = 1'b1;
        cyc();
        cyc();
        bus.halt      = 1'b1;
        bus.jmp_en    = 1'b1;
        bus.jmp_addr  = 8'h20;
        bus.exec_done = 1'b1;
        cyc();
        bus.halt      = 1'b0;
        bus.jmp_en    = 1'b0;
        bus.exec_done = 1'b0;
        #1;
        checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL halt_flag: got %b want 1", bus.halted); end
        checks++; if (bus.pc !== 8'h20) begin errors++; $display("FAIL halt_pc: got %h want 20", bus.pc); end
        checks++; if (bus.mem_rd !== 1'b0 || bus.fetch !== FETCH_HOLD) begin
            errors++; $display("FAIL halt_bus: got rd=%b fetch=%b want rd=0 fetch=00", bus.mem_rd, bus.fetch);
        end
        bus.exec_done = 1'b1;
        cyc();
        cyc();
        bus.exec_done = 1'b0;
        #1;
        checks++; if (bus.halted !== 1'b1 || bus.pc !== 8'h20 || bus.mem_rd !== 1'b0) begin
            errors++; $display("FAIL halt_absorb: got halted=%b pc=%h rd=%b want 1 20 0", bus.halted, bus.pc, bus.mem_rd);
        end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.halted !== 1'b0 || bus.pc !== 8'h00) begin
            errors++; $display("FAIL halt_reset: got halted=%b pc=%h want 0 00", bus.halted, bus.pc);
        end
    endtask

    task automatic test_reset_mid_f2();
        mem[8'h00] = 8'h9A;
        mem[8'h01] = 8'h3C;
        apply_reset();
        bus.mem_rdy = 1'b1;
        rst_n = 1'b1;
        cyc(); #1;
        checks++; if (bus.fetch !== FETCH_P2) begin errors++; $display("FAIL abort_in_f2: got %b want 10", bus.fetch); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.fetch !== FETCH_HOLD || bus.mem_rd !== 1'b0) begin
            errors++; $display("FAIL abort_outputs: got fetch=%b rd=%b want 00 0", bus.fetch, bus.mem_rd);
        end
        checks++; if (bus.pc !== 8'h00 || bus.mem_addr !== 8'h00) begin
            errors++; $display("FAIL abort_pc: got pc=%h addr=%h want 00 00", bus.pc, bus.mem_addr);
        end
        cyc();
        checks++; if (ir_mem !== 8'h12) begin errors++; $display("FAIL abort_ir_kept: got %h want 12", ir_mem); end
        rst_n = 1'b1;
        #1;
        checks++; if (bus.fetch !== FETCH_P1 || bus.mem_addr !== 8'h00 || bus.mem_rd !== 1'b1) begin
            errors++; $display("FAIL abort_restart: got fetch=%b addr=%h rd=%b want 01 00 1", bus.fetch, bus.mem_addr, bus.mem_rd);
        end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        rst_n         = 1'b0;
        bus.mem_rdy   = 1'b0;
        bus.exec_done = 1'b0;
        bus.jmp_en    = 1'b0;
        bus.halt      = 1'b0;
        bus.jmp_addr  = 8'h00;
        @(negedge clk);
        test_reset();
        test_one_byte();
        test_two_byte();
        test_wait_states();
        test_jump();
        test_wrap();
        test_halt();
        test_reset_mid_f2();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
